// File: rtl/capture_sequencer_if.sv
// Capture-engine and DMA-stream signals seen by the capture sequencer.
// master = sequencer side, slave = capture engine / FIFO / DMA side.
interface capture_sequencer_if #(
   parameter int saddr_w = 24
);
   logic [saddr_w-1:0] buffer_size;
   logic [saddr_w-1:0] post_trigger_count;
   logic               cap_arm;
   logic               cap_abort;
   logic               cap_armed;
   logic               cap_triggered;
   logic               cap_done;
   logic               cap_ready;
   logic               cap_overrun;
   logic               dma_valid;
   logic               dma_ready;
   logic               dma_last;

   modport master (
      output buffer_size, post_trigger_count, cap_arm, cap_abort, dma_last,
      input  cap_armed, cap_triggered, cap_done, cap_ready, cap_overrun,
             dma_valid, dma_ready
   );

   modport slave (
      input  buffer_size, post_trigger_count, cap_arm, cap_abort, dma_last,
      output cap_armed, cap_triggered, cap_done, cap_ready, cap_overrun,
             dma_valid, dma_ready
   );
endinterface

// File: rtl/capture_sequencer.sv
// Logic-analyser capture sequencer: arms the capture engine, counts DMA beats, raises tlast/irq.
// Optional trigger timeout enabled by defining LOGICAP_TRIG_TIMEOUT_EN.
// DMA handshake: a beat is transferred in any cycle where dma_valid and dma_ready are both high;
// dma_last is combinational and qualifies the beat currently offered on dma_valid.
module capture_sequencer #(
   parameter int saddr_w   = 24,
   parameter int timeout_w = 32
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 start,
   input  logic                 abort_req,
   input  logic [saddr_w-1:0]   cfg_buffer_size,
   input  logic [saddr_w-1:0]   cfg_post_count,
`ifdef LOGICAP_TRIG_TIMEOUT_EN
   input  logic [timeout_w-1:0] trig_timeout,
`endif
   capture_sequencer_if.master  bus,
   output logic [saddr_w-1:0]   beat_count,
   output logic                 busy,
   output logic [2:0]           state,
   output logic                 irq,
   output logic [1:0]           error
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      ARM       = 3'd1,
      WAIT_TRIG = 3'd2,
      WAIT_DONE = 3'd3,
      DRAIN     = 3'd4,
      COMPLETE  = 3'd5,
      ABORT     = 3'd6
   } state_t;

   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_OVERRUN = 2'd1;
   localparam logic [1:0] ERR_ABORT   = 2'd2;
   localparam logic [1:0] ERR_TIMEOUT = 2'd3;

   state_t             state_q, state_d;
   logic [saddr_w-1:0] size_q, size_d;
   logic [saddr_w-1:0] post_q, post_d;
   logic [saddr_w-1:0] cnt_q, cnt_d;
   logic [1:0]         error_q, error_d;
   logic               irq_q, irq_d;
   logic               arm_q, arm_d;
   logic               abort_q, abort_d;

   logic               beat;
   logic               streaming;
   logic               at_last;
   logic               cfg_ok;
   logic               timeout_hit;
   logic               unused_armed;

   // Engine status only; sequencing is driven by cap_triggered/cap_done.
   assign unused_armed = bus.cap_armed;

   assign beat      = bus.dma_valid & bus.dma_ready;
   assign streaming = (state_q == WAIT_TRIG) || (state_q == WAIT_DONE) || (state_q == DRAIN);
   assign at_last   = (cnt_q == size_q - saddr_w'(1));
   assign cfg_ok    = (cfg_buffer_size != '0) && (cfg_post_count <= cfg_buffer_size);

`ifdef LOGICAP_TRIG_TIMEOUT_EN
   logic [timeout_w-1:0] to_cnt_q;

   // Zero on the first WAIT_TRIG cycle, so the abort lands trig_timeout cycles after entry.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         to_cnt_q <= '0;
      end else if (state_q != WAIT_TRIG) begin
         to_cnt_q <= '0;
      end else begin
         to_cnt_q <= to_cnt_q + timeout_w'(1);
      end
   end

   assign timeout_hit = (state_q == WAIT_TRIG) && (trig_timeout != '0) &&
                        ((to_cnt_q + timeout_w'(1)) == trig_timeout);
`else
   logic [timeout_w-1:0] unused_timeout_w;
   assign unused_timeout_w = '0;
   assign timeout_hit      = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         size_q  <= '0;
         post_q  <= '0;
         cnt_q   <= '0;
         error_q <= ERR_NONE;
         irq_q   <= 1'b0;
         arm_q   <= 1'b0;
         abort_q <= 1'b0;
      end else begin
         state_q <= state_d;
         size_q  <= size_d;
         post_q  <= post_d;
         cnt_q   <= cnt_d;
         error_q <= error_d;
         irq_q   <= irq_d;
         arm_q   <= arm_d;
         abort_q <= abort_d;
      end
   end

   always_comb begin
      state_d = state_q;
      size_d  = size_q;
      post_d  = post_q;
      cnt_d   = cnt_q;
      error_d = error_q;
      irq_d   = 1'b0;
      arm_d   = 1'b0;
      abort_d = 1'b0;

      // Pre-trigger data may stream early; saturate rather than wrap.
      if (streaming && beat && (cnt_q != size_q)) begin
         cnt_d = cnt_q + saddr_w'(1);
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               if (cfg_ok) begin
                  size_d  = cfg_buffer_size;
                  post_d  = cfg_post_count;
                  cnt_d   = '0;
                  error_d = ERR_NONE;
                  state_d = ARM;
               end else begin
                  error_d = ERR_ABORT;
                  irq_d   = 1'b1;
               end
            end
         end
         ARM: begin
            if (bus.cap_ready) begin
               arm_d   = 1'b1;
               state_d = WAIT_TRIG;
            end
         end
         WAIT_TRIG: begin
            if (bus.cap_triggered && bus.cap_done) begin
               state_d = DRAIN;
            end else if (bus.cap_triggered) begin
               state_d = WAIT_DONE;
            end
         end
         WAIT_DONE: begin
            if (bus.cap_done) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            // A buffer already filled before DRAIN completes without another beat.
            if ((beat && at_last) || (cnt_q == size_q)) begin
               irq_d   = 1'b1;
               state_d = COMPLETE;
            end
         end
         COMPLETE: begin
            state_d = IDLE;
         end
         ABORT: begin
            if (bus.cap_ready) begin
               irq_d   = 1'b1;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Overrun beats software abort beats timeout; all of them beat normal sequencing.
      if ((state_q != IDLE) && (state_q != ABORT)) begin
         if (bus.cap_overrun || abort_req || timeout_hit) begin
            state_d = ABORT;
            abort_d = 1'b1;
            irq_d   = 1'b0;
            arm_d   = 1'b0;
            if (bus.cap_overrun) begin
               error_d = ERR_OVERRUN;
            end else if (abort_req) begin
               error_d = (error_q == ERR_NONE) ? ERR_ABORT : error_q;
            end else begin
               error_d = ERR_TIMEOUT;
            end
         end
      end
   end

   assign bus.buffer_size        = size_q;
   assign bus.post_trigger_count = post_q;
   assign bus.cap_arm            = arm_q;
   assign bus.cap_abort          = abort_q;
   assign bus.dma_last           = bus.dma_valid && streaming && at_last;

   assign beat_count = cnt_q;
   assign busy       = (state_q != IDLE);
   assign state      = state_q;
   assign irq        = irq_q;
   assign error      = error_q;

endmodule

// File: tb/tb_capture_sequencer.sv
// Directed bench for capture_sequencer: normal, back-pressure, saturation, abort, overrun,
// invalid/busy start, async reset and (with LOGICAP_TRIG_TIMEOUT_EN) trigger timeout.
module tb_capture_sequencer;
   localparam int SW = 24;
   localparam int TW = 32;

   logic          clk;
   logic          reset_n;
   logic          start;
   logic          abort_req;
   logic [SW-1:0] cfg_buffer_size;
   logic [SW-1:0] cfg_post_count;
   logic [SW-1:0] beat_count;
   logic          busy;
   logic [2:0]    state;
   logic          irq;
   logic [1:0]    error;
`ifdef LOGICAP_TRIG_TIMEOUT_EN
   logic [TW-1:0] trig_timeout;
`endif

   capture_sequencer_if #(.saddr_w(SW)) bus ();

   capture_sequencer #(.saddr_w(SW), .timeout_w(TW)) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .start           (start),
      .abort_req       (abort_req),
      .cfg_buffer_size (cfg_buffer_size),
      .cfg_post_count  (cfg_post_count),
`ifdef LOGICAP_TRIG_TIMEOUT_EN
      .trig_timeout    (trig_timeout),
`endif
      .bus             (bus),
      .beat_count      (beat_count),
      .busy            (busy),
      .state           (state),
      .irq             (irq),
      .error           (error)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // per-run observations
   int arm_n, arm_cyc, abort_n, abort_cyc, irq_n, irq_cyc;
   int last_hi, last_beat, sent, final_cyc;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      start              = 1'b0;
      abort_req          = 1'b0;
      bus.cap_armed      = 1'b0;
      bus.cap_triggered  = 1'b0;
      bus.cap_done       = 1'b0;
      bus.cap_ready      = 1'b1;
      bus.cap_overrun    = 1'b0;
      bus.dma_valid      = 1'b0;
      bus.dma_ready      = 1'b0;
   endtask

   // One capture, cycle c=0 carries start. Beats are offered from c=8 until n_beats accepted.
   task automatic run(input int size, input int post, input int trig_c, input int done_c,
                      input int n_beats, input bit bp, input int abort_c, input int overrun_c,
                      input int rdy_lo, input int rdy_hi, input int start2_c, input int max_c);
      arm_n = 0; arm_cyc = -1; abort_n = 0; abort_cyc = -1; irq_n = 0; irq_cyc = -1;
      last_hi = 0; last_beat = -1; sent = 0; final_cyc = -1;
      cfg_buffer_size = SW'(size);
      cfg_post_count  = SW'(post);
      for (int c = 0; c < max_c; c++) begin
         if (c == 1) begin
            cfg_buffer_size = SW'(8);
            cfg_post_count  = SW'(4);
         end
         start             = (c == 0) || (c == start2_c);
         abort_req         = (c == abort_c);
         bus.cap_overrun   = (c == overrun_c);
         bus.cap_triggered = (c == trig_c);
         bus.cap_done      = (c == done_c);
         bus.cap_armed     = (c >= 3);
         bus.cap_ready     = !((c >= rdy_lo) && (c < rdy_hi));
         bus.dma_valid     = (c >= 8) && (sent < n_beats);
         bus.dma_ready     = bp ? c[0] : 1'b1;
         @(negedge clk);
         if (bus.cap_arm) begin arm_n++; arm_cyc = c; end
         if (bus.cap_abort) begin abort_n++; abort_cyc = c; end
         if (irq) begin irq_n++; irq_cyc = c; end
         if (bus.dma_last) last_hi++;
         if (bus.dma_valid && bus.dma_ready) begin
            sent++;
            if (bus.dma_last) last_beat = sent;
            if (sent == n_beats) final_cyc = c;
         end
         step();
         if (irq_n > 0) break;
      end
      check("run_irq_seen", 32'(irq_n), 32'd1);
      check("irq_one_cycle", 32'(irq), 32'd0);
      check("state_idle_end", 32'(state), 32'd0);
      check("busy_end", 32'(busy), 32'd0);
      idle_inputs();
      step();
      step();
   endtask

   initial begin
      reset_n         = 1'b0;
      cfg_buffer_size = '0;
      cfg_post_count  = '0;
      idle_inputs();
`ifdef LOGICAP_TRIG_TIMEOUT_EN
      trig_timeout = '0;
`endif
      step();
      step();
      check("rst_state", 32'(state), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_irq", 32'(irq), 32'd0);
      check("rst_error", 32'(error), 32'd0);
      check("rst_beat_count", 32'(beat_count), 32'd0);
      check("rst_buffer_size", 32'(bus.buffer_size), 32'd0);
      check("rst_cap_arm", 32'(bus.cap_arm), 32'd0);
      check("rst_cap_abort", 32'(bus.cap_abort), 32'd0);
      reset_n = 1'b1;
      step();

      // invalid config: post > size
      run(16, 32, 500, 500, 0, 0, -1, -1, -1, -1, -1, 20);
      check("inv_arm", 32'(arm_n), 32'd0);
      check("inv_irq_cyc", 32'(irq_cyc), 32'd1);
      check("inv_error", 32'(error), 32'd2);

      // invalid config: size 0
      run(0, 0, 500, 500, 0, 0, -1, -1, -1, -1, -1, 20);
      check("inv0_arm", 32'(arm_n), 32'd0);
      check("inv0_error", 32'(error), 32'd2);

      // normal capture with an ignored start at c=30
      run(128, 64, 20, 90, 128, 0, -1, -1, -1, -1, 30, 400);
      check("norm_arm_n", 32'(arm_n), 32'd1);
      check("norm_arm_cyc", 32'(arm_cyc), 32'd2);
      check("norm_abort_n", 32'(abort_n), 32'd0);
      check("norm_last_hi", 32'(last_hi), 32'd1);
      check("norm_last_beat", 32'(last_beat), 32'd128);
      check("norm_final_cyc", 32'(final_cyc), 32'd135);
      check("norm_irq_cyc", 32'(irq_cyc), 32'd136);
      check("norm_error", 32'(error), 32'd0);
      check("norm_beat_count", 32'(beat_count), 32'd128);
      check("norm_buffer_size", 32'(bus.buffer_size), 32'd128);
      check("norm_post_count", 32'(bus.post_trigger_count), 32'd64);

      // back-pressure: ready on odd cycles, last held over one stalled cycle
      run(128, 64, 20, 90, 128, 1, -1, -1, -1, -1, -1, 600);
      check("bp_last_hi", 32'(last_hi), 32'd2);
      check("bp_last_beat", 32'(last_beat), 32'd128);
      check("bp_final_cyc", 32'(final_cyc), 32'd263);
      check("bp_irq_cyc", 32'(irq_cyc), 32'd264);
      check("bp_beat_count", 32'(beat_count), 32'd128);
      check("bp_error", 32'(error), 32'd0);

      // all beats before done, 8 extra beats must saturate
      run(8, 4, 3, 40, 16, 0, -1, -1, -1, -1, -1, 100);
      check("sat_last_hi", 32'(last_hi), 32'd1);
      check("sat_last_beat", 32'(last_beat), 32'd8);
      check("sat_beat_count", 32'(beat_count), 32'd8);
      check("sat_irq_cyc", 32'(irq_cyc), 32'd42);

      // abort in WAIT_TRIG, engine not ready for 4 cycles
      run(64, 32, 200, 300, 0, 0, 10, -1, 11, 15, -1, 100);
      check("abt_abort_n", 32'(abort_n), 32'd1);
      check("abt_abort_cyc", 32'(abort_cyc), 32'd11);
      check("abt_irq_cyc", 32'(irq_cyc), 32'd16);
      check("abt_error", 32'(error), 32'd2);
      check("abt_last_hi", 32'(last_hi), 32'd0);

      // overrun in DRAIN after 50 beats; ARM delayed by cap_ready low
      run(64, 32, 10, 20, 50, 0, -1, 60, 1, 5, -1, 200);
      check("ovr_arm_cyc", 32'(arm_cyc), 32'd6);
      check("ovr_abort_cyc", 32'(abort_cyc), 32'd61);
      check("ovr_irq_cyc", 32'(irq_cyc), 32'd62);
      check("ovr_error", 32'(error), 32'd1);
      check("ovr_beat_count", 32'(beat_count), 32'd50);
      check("ovr_last_hi", 32'(last_hi), 32'd0);

`ifdef LOGICAP_TRIG_TIMEOUT_EN
      trig_timeout = TW'(100);
      run(64, 32, -1, -1, 0, 0, -1, -1, -1, -1, -1, 400);
      check("to_abort_cyc", 32'(abort_cyc), 32'd102);
      check("to_irq_cyc", 32'(irq_cyc), 32'd103);
      check("to_error", 32'(error), 32'd3);

      trig_timeout = '0;
      run(64, 32, -1, -1, 0, 0, 10002, -1, -1, -1, -1, 10100);
      check("to0_abort_cyc", 32'(abort_cyc), 32'd10003);
      check("to0_error", 32'(error), 32'd2);
`endif

      // asynchronous reset mid-capture
      cfg_buffer_size = SW'(32);
      cfg_post_count  = SW'(16);
      start = 1'b1;
      step();
      start = 1'b0;
      bus.dma_valid = 1'b1;
      bus.dma_ready = 1'b1;
      for (int i = 0; i < 6; i++) step();
      check("mid_busy", 32'(busy), 32'd1);
      #2;
      reset_n = 1'b0;
      #1;
      check("arst_state", 32'(state), 32'd0);
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_beat_count", 32'(beat_count), 32'd0);
      check("arst_buffer_size", 32'(bus.buffer_size), 32'd0);
      check("arst_cap_abort", 32'(bus.cap_abort), 32'd0);
      check("arst_dma_last", 32'(bus.dma_last), 32'd0);
      idle_inputs();
      step();
      reset_n = 1'b1;
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/capture_sequencer.md
Name: capture_sequencer

Overview:
- Control block for the logic-analyser datapath: the capture engine, the sample FIFO and the DMA stream.
- Latches capture configuration on a start command, pulses arm to the capture engine and tracks it through armed, triggered and done.
- Counts DMA beats leaving the FIFO and generates the stream tlast on the final sample.
- Reports status and a completion/error interrupt to software.

Parameters:
- saddr_w, 24, width of sample counts and addresses
- timeout_w, 32, width of the trigger-timeout counter (used only with the optional feature)

Ports:
- clk  in  1  system clock; also the FIFO master clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle start command from the register block
- abort_req  in  1  single-cycle software abort
- cfg_buffer_size  in  saddr_w  total samples per capture
- cfg_post_count  in  saddr_w  samples captured after the trigger
- buffer_size  out  saddr_w  latched buffer size, drives the capture engine
- post_trigger_count  out  saddr_w  latched post-trigger count, drives the capture engine
- cap_arm  out  1  arm pulse to the capture engine
- cap_abort  out  1  abort pulse to the capture engine
- cap_armed  in  1  capture engine armed
- cap_triggered  in  1  capture engine triggered
- cap_done  in  1  capture engine finished sampling
- cap_ready  in  1  capture engine idle and able to accept arm
- cap_overrun  in  1  sample overrun flag
- dma_valid  in  1  FIFO master tvalid
- dma_ready  in  1  DMA tready
- dma_last  out  1  tlast for the DMA stream
- beat_count  out  saddr_w  DMA beats transferred in the current capture
- busy  out  1  sequencer not idle
- state  out  3  current state encoding
- irq  out  1  single-cycle completion/error pulse
- error  out  2  sticky error code: 0 none, 1 overrun, 2 abort, 3 timeout

Behaviour:
- Reset values: all outputs 0. State is IDLE. Latched configuration registers are 0.
- States and encodings: IDLE=0, ARM=1, WAIT_TRIG=2, WAIT_DONE=3, DRAIN=4, COMPLETE=5, ABORT=6.
- A beat is dma_valid & dma_ready.
- IDLE:
  - start with cfg_buffer_size != 0 and cfg_post_count <= cfg_buffer_size: latch both configs, clear beat_count and error, go to ARM.
  - start with an invalid config (size 0 or post > size): stay IDLE and pulse irq with error=2.
  - start while busy is ignored.
- ARM: wait for cap_ready. Then assert cap_arm for exactly 1 cycle and go to WAIT_TRIG.
- WAIT_TRIG: cap_triggered moves to WAIT_DONE. If cap_triggered and cap_done arrive in the same cycle, go directly to DRAIN.
- WAIT_DONE: cap_done moves to DRAIN.
- Beat counting:
  - beat_count increments on every beat in WAIT_TRIG, WAIT_DONE and DRAIN, because pre-trigger data can stream early.
  - beat_count saturates at buffer_size and never wraps.
- dma_last is combinational: high when dma_valid and beat_count == buffer_size-1, in any of those three states.
- DRAIN: the beat where beat_count == buffer_size-1 goes to COMPLETE.
- COMPLETE: pulse irq for 1 cycle, return to IDLE the next cycle. Latency from the last beat to irq is 1 cycle.
- Overrun: cap_overrun high in any non-IDLE state sets error=1 (sticky) and moves to ABORT. This takes priority over all other transitions except reset.
- Abort:
  - abort_req in any non-IDLE state moves to ABORT.
  - abort_req in IDLE is ignored.
  - If abort_req and the final beat coincide, abort wins.
- ABORT:
  - Assert cap_abort for 1 cycle. Set error=2 unless an error is already set.
  - Wait for cap_ready, then pulse irq and go to IDLE.
  - dma_last is forced low in ABORT.
- Error priority when events coincide: overrun > abort > timeout.
- busy = (state != IDLE).
- Asserting reset_n low mid-operation returns all state to reset values immediately. No cap_abort pulse is generated; the capture engine shares the reset.

Optional Feature:
- Macro: LOGICAP_TRIG_TIMEOUT_EN.
- When defined:
  - Adds input trig_timeout [timeout_w-1:0].
  - A counter clears on entry to WAIT_TRIG and increments each cycle in that state.
  - If trig_timeout != 0 and the counter reaches trig_timeout, set error=3 and go to ABORT.
  - trig_timeout == 0 disables the timeout.
- When undefined: no port and no counter. WAIT_TRIG waits indefinitely.

Test Plan:
- Normal capture: cfg 128/64; start; cap_ready=1; triggered at cycle 20, done at cycle 90; dma_ready=1 with 128 beats -> cap_arm pulses once, dma_last on beat 128 only, irq 1 cycle later, error=0, beat_count=128.
- Back-pressure: same as normal capture with dma_ready toggling every cycle -> dma_last is held with valid until accepted, exactly 128 beats counted, no extra beats.
- Abort: abort_req in WAIT_TRIG -> cap_abort 1-cycle pulse, error=2, irq after cap_ready, state=IDLE, dma_last never asserted.
- Overrun: cap_overrun pulse during DRAIN at beat 50 -> error=1, ABORT then IDLE, beat_count frozen at 50.
- Invalid config or busy start: cfg 16/32 -> no cap_arm, immediate irq, error=2. start while busy -> ignored.
- Trigger timeout (LOGICAP_TRIG_TIMEOUT_EN): trig_timeout=100, trigger never arrives -> ABORT 100 cycles after entering WAIT_TRIG, error=3. With trig_timeout=0 -> no timeout after 10000 cycles.
